audio_pwm_out: RTL

// Audio output stage downstream of the song ROM sequencer. Accepts the 4-bit ROM sample plus a
// one-cycle strobe at the sample rate (8 kHz). Converts it to a single-bit PWM stream for the

---
 rtl/audio_pwm_out_if.sv | 17 +
 rtl/audio_pwm_out.sv | 93 +++++++++
 2 files changed

// File: rtl/audio_pwm_out_if.sv
// audio_pwm_out_if: sample/control inputs and PWM/status outputs of the audio output stage.
interface audio_pwm_out_if #(parameter int SAMPLE_W = 4);
    logic [SAMPLE_W-1:0] sample_in;
    logic                sample_stb;
    logic                enable;
    logic [SAMPLE_W-1:0] volume;
    logic                clr_status;
    logic                pwm_out;
    logic                frame_start;
    logic                playing;
    logic                overrun;
    logic [7:0]          underrun_cnt;
    modport master (output sample_in, sample_stb, enable, volume, clr_status,
                    input  pwm_out, frame_start, playing, overrun, underrun_cnt);
    modport slave  (input  sample_in, sample_stb, enable, volume, clr_status,
                    output pwm_out, frame_start, playing, overrun, underrun_cnt);
endinterface

// File: rtl/audio_pwm_out.sv
// audio_pwm_out: sample buffer, click-free gain ramp and PWM generator for the board audio pin.
module audio_pwm_out #(
    parameter int SAMPLE_W    = 4,
    parameter int PWM_BITS    = 8,
    parameter int RAMP_FRAMES = 16
) (
    input logic              clk50Mghz,
    input logic              reset_n,
    audio_pwm_out_if.slave   bus
);
    localparam int TW = RAMP_FRAMES > 1 ? $clog2(RAMP_FRAMES) : 1;
    typedef enum logic [1:0] {MUTED, RAMP_UP, PLAY, RAMP_DOWN} state_t;
    state_t                  state, state_nxt;
    logic [SAMPLE_W-1:0]     gain, gain_nxt, pending, active, active_nxt;
    logic [TW-1:0]           timer, timer_nxt;
    logic [PWM_BITS-1:0]     cnt, cnt_nxt, duty, duty_nxt;
    logic [2*SAMPLE_W-1:0]   prod;
    logic                    full, bnd, step, inc;
    assign bnd        = &cnt;
    assign cnt_nxt    = cnt + 1'b1;
    assign step       = timer == TW'(RAMP_FRAMES - 1);
    assign inc        = bnd & ~full & ~bus.sample_stb;
    // a strobe landing on an empty buffer at the boundary bypasses pending
    assign active_nxt = !bnd ? active : full ? pending : bus.sample_stb ? bus.sample_in : active;
    assign prod       = {{SAMPLE_W{1'b0}}, active_nxt} * {{SAMPLE_W{1'b0}}, gain_nxt};
    assign duty_nxt   = bnd ? PWM_BITS'(prod) : duty;
    always_ff @(posedge clk50Mghz) begin
        if (!reset_n) begin
            state <= MUTED;
            gain  <= '0;
            timer <= '0;
        end else begin
            state <= state_nxt;
            gain  <= gain_nxt;
            timer <= timer_nxt;
        end
    end
    always_comb begin
        state_nxt = state;
        gain_nxt  = gain;
        if (bnd) begin
            case (state)
                MUTED: state_nxt = bus.enable ? RAMP_UP : MUTED;
                RAMP_UP:
                    if (!bus.enable) state_nxt = RAMP_DOWN;
                    else if (gain >= bus.volume) state_nxt = PLAY;
                    else if (step) begin
                        gain_nxt  = gain + 1'b1;
                        state_nxt = gain_nxt == bus.volume ? PLAY : RAMP_UP;
                    end
                PLAY:
                    if (!bus.enable) state_nxt = RAMP_DOWN;
                    else if (gain != bus.volume && step) gain_nxt = gain < bus.volume ? gain + 1'b1 : gain - 1'b1;
                RAMP_DOWN:
                    if (bus.enable) state_nxt = RAMP_UP;
                    else if (gain == '0) state_nxt = MUTED;
                    else if (step) begin
                        gain_nxt  = gain - 1'b1;
                        state_nxt = gain_nxt == '0 ? MUTED : RAMP_DOWN;
                    end
                default: state_nxt = MUTED;
            endcase
        end
        timer_nxt = !bnd ? timer
                  : (state_nxt != state || step || state == MUTED || (state == PLAY && gain == bus.volume)) ? '0
                  : timer + 1'b1;
    end
    always_comb bus.playing = state == PLAY;
    always_ff @(posedge clk50Mghz) begin
        if (!reset_n) begin
            cnt              <= '0;
            duty             <= '0;
            pending          <= '0;
            active           <= '0;
            full             <= 1'b0;
            bus.pwm_out      <= 1'b0;
            bus.frame_start  <= 1'b0;
            bus.overrun      <= 1'b0;
            bus.underrun_cnt <= '0;
        end else begin
            cnt              <= cnt_nxt;
            duty             <= duty_nxt;
            active           <= active_nxt;
            pending          <= bus.sample_stb ? bus.sample_in : pending;
            full             <= bnd ? full & bus.sample_stb : full | bus.sample_stb;
            bus.pwm_out      <= cnt_nxt < duty_nxt;
            bus.frame_start  <= bnd;
            bus.overrun      <= (bus.sample_stb & full & ~bnd) | (bus.overrun & ~bus.clr_status);
            bus.underrun_cnt <= inc ? (bus.clr_status ? 8'd1 : bus.underrun_cnt + {7'd0, ~&bus.underrun_cnt})
                              : bus.clr_status ? 8'd0 : bus.underrun_cnt;
        end
    end
endmodule
